// File: rtl/if_stage.sv
// if_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register of the pipelined
// MIPS-style CPU. Holds the program counter, presents it as the
// instruction-memory address and latches the fetched word together with its
// PC+4 for the decode stage. Load-use stalls freeze the stage; redirects from
// later stages load a new PC and flush IF/ID with a bubble.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   stall_i        hold PC, IF/ID and the fetch counter this cycle
//   redirect_i     load redirect_pc_i into PC and flush IF/ID
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_addr_o    instruction-memory address (current PC)
//   imem_rdata_i   instruction word at imem_addr_o, same-cycle read
//   id_instr_o     IF/ID instruction
//   id_pc4_o       IF/ID PC+4 of that instruction
//   id_valid_o     IF/ID holds a real instruction (0 = bubble)
//   id_imm16_o     low 16 bits of id_instr_o, for the decode sign extender
//   fetch_count_o  instructions accepted into IF/ID since reset
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc4_o,
  output logic        id_valid_o,
  output logic [15:0] id_imm16_o,
  output logic [31:0] fetch_count_o
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] fetch_count_reg, fetch_count_next;
  logic [31:0] pc_plus4;

  // Targets are always word aligned, so the low bits of the redirect
  // address are deliberately dropped.
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc_i[1:0];

  // Modulo-2^32: 32'hFFFF_FFFC advances to 0.
  assign pc_plus4 = pc_reg + 32'd4;

  // Next-state selection; redirect outranks stall so a wrong-path stall
  // can never hold a flushed instruction in IF/ID.
  always_comb begin
    pc_next          = pc_reg;
    id_instr_next    = id_instr_reg;
    id_pc4_next      = id_pc4_reg;
    id_valid_next    = id_valid_reg;
    fetch_count_next = fetch_count_reg;
    if (redirect_i) begin
      pc_next       = {redirect_pc_i[31:2], 2'b00};
      id_instr_next = NOP_WORD;
      id_pc4_next   = 32'd0;
      id_valid_next = 1'b0;
    end else if (!stall_i) begin
      pc_next          = pc_plus4;
      id_instr_next    = imem_rdata_i;
      id_pc4_next      = pc_plus4;
      id_valid_next    = 1'b1;
      fetch_count_next = fetch_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      id_instr_reg    <= NOP_WORD;
      id_pc4_reg      <= 32'd0;
      id_valid_reg    <= 1'b0;
      fetch_count_reg <= 32'd0;
    end else begin
      pc_reg          <= pc_next;
      id_instr_reg    <= id_instr_next;
      id_pc4_reg      <= id_pc4_next;
      id_valid_reg    <= id_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign imem_addr_o   = pc_reg;
  assign id_instr_o    = id_instr_reg;
  assign id_pc4_o      = id_pc4_reg;
  assign id_valid_o    = id_valid_reg;
  assign id_imm16_o    = id_instr_reg[15:0];
  assign fetch_count_o = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized
// stall/redirect/reset traffic, all compared against a transaction-level
// model of the fetch stage kept in this file.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc4_o;
  logic        id_valid_o;
  logic [15:0] id_imm16_o;
  logic [31:0] fetch_count_o;

  // 0: word = addr>>2, 1: scrambled word, 2: constant with imm 0x8001
  int mode = 0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .id_instr_o    (id_instr_o),
    .id_pc4_o      (id_pc4_o),
    .id_valid_o    (id_valid_o),
    .id_imm16_o    (id_imm16_o),
    .fetch_count_o (fetch_count_o)
  );

  function automatic logic [31:0] mem_word(input int md, input logic [31:0] a);
    if (md == 0)      return a >> 2;
    else if (md == 1) return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    else              return 32'h2008_8001;
  endfunction

  assign imem_rdata_i = mem_word(mode, imem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model by the stage's rules,
  // then compare every output.
  task automatic step(input logic rn, input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] word;
    @(negedge clk);
    rst_n = rn; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    word = mem_word(mode, m_pc);
    @(posedge clk);
    if (!rn) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      m_pc = rpc & ~32'd3; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = word; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
    end
    #1;
    check("imem_addr", imem_addr_o, m_pc);
    check("id_instr", id_instr_o, m_instr);
    check("id_pc4", id_pc4_o, m_pc4);
    check("id_valid", {31'd0, id_valid_o}, {31'd0, m_valid});
    check("id_imm16", {16'd0, id_imm16_o}, {16'd0, m_instr[15:0]});
    check("fetch_count", fetch_count_o, m_cnt);
    $display("cyc rst_n=%0b stall=%0b redir=%0b rpc=%h | addr=%h instr=%h pc4=%h v=%0b cnt=%0d",
             rn, st, rd, rpc, imem_addr_o, id_instr_o, id_pc4_o, id_valid_o, fetch_count_o);
  endtask

  initial begin
    logic [31:0] cnt_snap;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    m_pc = 32'hX; m_instr = 32'hX; m_pc4 = 32'hX; m_valid = 1'bX; m_cnt = 32'hX;

    // Reset
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_1234);
    check("reset_addr", imem_addr_o, 32'h0);
    check("reset_count", fetch_count_o, 32'h0);

    // Free run: words 0,1,2,3 with pc4 4,8,12,16
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("seq_instr", id_instr_o, i);
      check("seq_pc4", id_pc4_o, 4 * (i + 1));
    end
    check("seq_count", fetch_count_o, 32'd4);

    // Stall 3 cycles at pc=0x10
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_addr", imem_addr_o, 32'h10);
      check("stall_instr", id_instr_o, 32'd3);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("resume_instr", id_instr_o, 32'd4);
    check("resume_pc4", id_pc4_o, 32'h14);

    // Redirect to 0x203 while stalled
    cnt_snap = fetch_count_o;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    check("redir_addr", imem_addr_o, 32'h200);
    check("redir_bubble", {31'd0, id_valid_o}, 32'd0);
    check("redir_count", fetch_count_o, cnt_snap);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_target", id_instr_o, 32'h80);

    // PC wrap
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr1", imem_addr_o, 32'h0);
    check("wrap_pc4", id_pc4_o, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset during a stall, then resume from RESET_PC
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("midrst_addr", imem_addr_o, 32'h0);
    check("midrst_count", fetch_count_o, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("midrst_resume", id_pc4_o, 32'h4);

    // Immediate path
    mode = 2;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("imm_instr", id_instr_o, 32'h2008_8001);
    check("imm16", {16'd0, id_imm16_o}, 32'h0000_8001);

    // Randomized traffic
    mode = 1;
    for (int i = 0; i < 1500; i++) begin
      logic rn, st, rd;
      logic [31:0] rpc;
      rn  = ($urandom_range(0, 99) >= 2);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step(rn, st, rd, rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
